add_pipe: RTL and testbench
===========================

Name: add_pipe

Overview:
- Parametrised, pipelined integer adder/subtractor.
- Successor to the single-cycle 32-bit add unit in the ALU datapath.
- Splits the carry chain into STAGES segments, one segment per clock.
- Produces ARM-style N/Z/C/V flags with correct signed/unsigned semantics.
- Valid/ready handshake with back-pressure, so the execute stage can stall it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline stages (1..8); each stage resolves WIDTH/STAGES bits of the carry chain.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op present this cycle.
- in_ready  out  1  stage 0 can accept; transfer occurs when in_valid && in_ready.
- data1  in  WIDTH  operand A.
- data2  in  WIDTH  operand B.
- op  in  2  00 ADD, 01 SUB (A-B), 10 ADC (A+B+cin), 11 SBC (A-B-1+cin).
- cin  in  1  carry-in; used only for ADC/SBC.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- n, z, c, v  out  1 each  negative, zero, carry (SUB: 1 = no borrow), signed overflow.

Behaviour:
- Reset (async, reset=1): all stage valid bits 0; out_valid=0; result=0; n=z=c=v=0. Takes effect immediately, mid-operation included; in-flight operations are discarded, never emitted.
- Operand prep at acceptance:
  - B' = data2 for ADD/ADC, ~data2 for SUB/SBC.
  - carry0 = 0 for ADD, 1 for SUB, cin for ADC/SBC.
- Stage k (0..STAGES-1):
  - Adds segment k of A and B' plus the carry from stage k-1 (carry0 for k=0).
  - Registers the partial sum, the carry out, and the not-yet-consumed upper segments of A/B'.
- Final stage registers the flags:
  - c = carry out of bit WIDTH-1.
  - v = (A[W-1]==B'[W-1]) && (result[W-1]!=A[W-1]).
  - n = result[W-1]; z = (result==0).
- Latency: exactly STAGES cycles from input handshake to out_valid with no stall. Throughput 1 op/cycle.
- Flow control, per stage k:
  - Advance enable = !valid[k+1] || advance[k+1]; last stage uses !out_valid || out_ready.
  - in_ready = stage 0 advance enable; combinational from out_ready through the chain (no skid buffer).
  - A stalled stage holds its data and valid unchanged.
  - Bubbles collapse: an empty stage accepts while downstream is stalled.
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous output accept and new final-stage data in the same cycle: output updates with the new data, out_valid stays 1.
- in_valid=0 with in_ready=1: stage 0 valid cleared; operand registers may hold garbage.
- STAGES=1 degenerates to a registered single-cycle adder, latency 1.
- Wrap-around: result is always modulo 2^WIDTH; overflow is reported only by the flags.

Optional Feature:
- Macro: ADD_PIPE_SATURATE_EN.
- Defined:
  - Adds input port sat (1 bit), sampled with the operands and carried down the pipe.
  - If sat=1 and v=1, result clamps to 2^(W-1)-1 when A is non-negative, else to -2^(W-1).
  - n and z are computed on the clamped value; v and c still report the raw operation.
- Not defined: no sat port; result always wraps.

Test Plan:
- WIDTH=32, STAGES=2, ADD 0x7FFFFFFF+0x00000001 -> 2 cycles later result=0x80000000, n=1 z=0 c=0 v=1.
- SUB 0x00000005-0x00000005 -> result=0, z=1 c=1 v=0 n=0. SUB 0-1 -> result=0xFFFFFFFF, c=0 n=1 v=0.
- ADC 0xFFFFFFFF+0x00000000, cin=1 -> result=0, c=1 z=1 v=0. SBC 0x10-0x01, cin=0 -> result=0x0E, c=1.
- Back-to-back stream of 8 ADDs with out_ready held 0 for cycles 3-6:
  - in_ready drops once both stages are full.
  - No op is lost or duplicated; results emerge in order.
  - Outputs stay stable during the stall.
- Assert reset while 2 ops are in flight -> out_valid=0 and all outputs 0 immediately; after release, the first new op appears after exactly STAGES cycles.
- With ADD_PIPE_SATURATE_EN, sat=1, ADD 0x7FFFFFFF+0x7FFFFFFF -> result=0x7FFFFFFF, v=1, n=0. SUB 0x80000000-0x00000001 -> result=0x80000000, v=1.

Source files
------------

// File: rtl/add_pipe.sv
`default_nettype none
//==============================================================================
// Module   : add_pipe
// Brief    : Pipelined WIDTH-bit add/sub with N/Z/C/V flags and valid/ready
//            flow control. Saturation enabled by ADD_PIPE_SATURATE_EN.
// Revision : 1.0 - initial release
//==============================================================================
module add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [1:0]       op,
  input  logic             cin,
`ifdef ADD_PIPE_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int c_seg_w = WIDTH / STAGES;

  // Per-stage inputs; entry k is what stage k consumes this cycle.
  logic             w_vld_in [STAGES];
  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_s_in   [STAGES];
  logic             w_c_in   [STAGES];
  logic             w_sat_in [STAGES];

  logic [WIDTH-1:0] w_s_nxt  [STAGES];
  logic             w_co     [STAGES];
  logic             w_vld_q  [STAGES];
  logic [STAGES-1:0] w_en;

  logic w_sat0;
`ifdef ADD_PIPE_SATURATE_EN
  assign w_sat0 = sat;
`else
  assign w_sat0 = 1'b0;
`endif

  // op[0] selects subtraction; op[1] takes the external carry.
  assign w_vld_in[0] = in_valid;
  assign w_a_in[0]   = data1;
  assign w_b_in[0]   = op[0] ? ~data2 : data2;
  assign w_s_in[0]   = '0;
  assign w_c_in[0]   = op[1] ? cin : op[0];
  assign w_sat_in[0] = w_sat0;

  always_comb begin : p_enable
    logic l_acc;
    w_en  = '0;
    l_acc = !w_vld_q[STAGES-1] || out_ready;
    w_en[STAGES-1] = l_acc;
    for (int k = STAGES - 2; k >= 0; k--) begin
      l_acc   = !w_vld_q[k] || l_acc;
      w_en[k] = l_acc;
    end
  end

  assign in_ready = w_en[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [c_seg_w:0]  w_seg;
    logic [WIDTH-1:0]  w_sum;

    assign w_seg = {1'b0, w_a_in[k][k*c_seg_w +: c_seg_w]}
                 + {1'b0, w_b_in[k][k*c_seg_w +: c_seg_w]}
                 + {{c_seg_w{1'b0}}, w_c_in[k]};

    always_comb begin
      w_sum = w_s_in[k];
      w_sum[k*c_seg_w +: c_seg_w] = w_seg[c_seg_w-1:0];
    end

    assign w_s_nxt[k] = w_sum;
    assign w_co[k]    = w_seg[c_seg_w];

    if (k < STAGES - 1) begin : g_mid
      logic             r_valid;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_sum;
      logic             r_carry;
      logic             r_sat;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_a     <= '0;
          r_b     <= '0;
          r_sum   <= '0;
          r_carry <= 1'b0;
          r_sat   <= 1'b0;
        end else if (w_en[k]) begin
          r_valid <= w_vld_in[k];
          if (w_vld_in[k]) begin
            r_a     <= w_a_in[k];
            r_b     <= w_b_in[k];
            r_sum   <= w_s_nxt[k];
            r_carry <= w_co[k];
            r_sat   <= w_sat_in[k];
          end
        end
      end

      assign w_vld_q[k]    = r_valid;
      assign w_vld_in[k+1] = r_valid;
      assign w_a_in[k+1]   = r_a;
      assign w_b_in[k+1]   = r_b;
      assign w_s_in[k+1]   = r_sum;
      assign w_c_in[k+1]   = r_carry;
      assign w_sat_in[k+1] = r_sat;
    end else begin : g_tail
      logic             r_valid;
      logic [WIDTH-1:0] r_result;
      logic             r_n;
      logic             r_z;
      logic             r_c;
      logic             r_v;
      logic             w_ovf;
      logic [WIDTH-1:0] w_res;

      // Overflow uses the effective operand B', so SUB/SBC need no special case.
      assign w_ovf = (w_a_in[k][WIDTH-1] == w_b_in[k][WIDTH-1])
                  && (w_s_nxt[k][WIDTH-1] != w_a_in[k][WIDTH-1]);

      always_comb begin
        w_res = w_s_nxt[k];
        if (w_sat_in[k] && w_ovf) begin
          w_res = w_a_in[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid  <= 1'b0;
          r_result <= '0;
          r_n      <= 1'b0;
          r_z      <= 1'b0;
          r_c      <= 1'b0;
          r_v      <= 1'b0;
        end else if (w_en[k]) begin
          r_valid <= w_vld_in[k];
          if (w_vld_in[k]) begin
            r_result <= w_res;
            r_n      <= w_res[WIDTH-1];
            r_z      <= (w_res == '0);
            r_c      <= w_co[k];
            r_v      <= w_ovf;
          end
        end
      end

      assign w_vld_q[k] = r_valid;
      assign out_valid  = r_valid;
      assign result     = r_result;
      assign n          = r_n;
      assign z          = r_z;
      assign c          = r_c;
      assign v          = r_v;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_pipe.sv
`default_nettype none
//==============================================================================
// Module   : tb_add_pipe
// Brief    : Directed self-checking bench for add_pipe (WIDTH=32, STAGES=2).
// Revision : 1.0 - initial release
//==============================================================================
module tb_add_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [1:0]       op;
  logic             cin;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             n, z, c, v;

  int n_vec = 0;
  int n_err = 0;

  int          sent, recv, cyc;
  logic        acc, have_hold;
  logic [31:0] held;
  logic [31:0] sa [8];
  logic [31:0] sb [8];

  add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .op        (op),
    .cin       (cin),
`ifdef ADD_PIPE_SATURATE_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .n         (n),
    .z         (z),
    .c         (c),
    .v         (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: checks acceptance, latency and result/flags {n,z,c,v}.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic s,
                       input logic [31:0] er, input logic [3:0] ef);
    op = o; data1 = a; data2 = b; cin = ci; sat = s;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check({tag, " early"}, 64'(out_valid), 64'd0);
    step();
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " nzcv"}, 64'({n, z, c, v}), 64'(ef));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; op = 2'b00;
    data1 = '0; data2 = '0; cin = 1'b0; sat = 1'b0;
    reset = 1'b1;
    #12;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst nzcv", 64'({n, z, c, v}), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    step();
    reset = 1'b0;
    step();

    do_op("add ovf",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b1001);
    do_op("sub eq",    2'b01, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0000, 4'b0110);
    do_op("sub 0-1",   2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    do_op("adc wrap",  2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'b0110);
    do_op("sbc c0",    2'b11, 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_000E, 4'b0010);
    do_op("sbc c1",    2'b11, 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_000F, 4'b0010);
    do_op("add seg",   2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 4'b0000);
    do_op("add negov", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0111);
    do_op("adc nocin", 2'b10, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 4'b0000);
    do_op("add ign ci",2'b00, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0003, 4'b0000);

    // Stream of 8 ADDs with the consumer stalled for cycles 3..6.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 32'(32'h1111_1111 * (i + 1));
      sb[i] = 32'(32'h0000_FFFF + i);
    end
    sent = 0; recv = 0; cyc = 0; have_hold = 1'b0; held = '0;
    op = 2'b00; cin = 1'b0; sat = 1'b0;
    while (recv < 8 && cyc < 60) begin
      out_ready = (cyc < 3 || cyc > 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        data1 = sa[sent];
        data2 = sb[sent];
      end
      #1;
      if (sent < 8)
        check("stream in_ready", 64'(in_ready), 64'(cyc < 3 || cyc > 6));
      if (have_hold)
        check("stall hold", 64'(result), 64'(held));
      if (out_valid && !out_ready) begin
        held = result;
        have_hold = 1'b1;
      end else begin
        have_hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("stream result", 64'(result), 64'(sa[recv] + sb[recv]));
        recv++;
      end
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) sent++;
    end
    check("stream count", 64'(recv), 64'd8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("stream drained", 64'(out_valid), 64'd0);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 2'b00; data1 = 32'd5; data2 = 32'd6;
    step();
    data1 = 32'd7; data2 = 32'd8;
    step();
    in_valid = 1'b0;
    check("pre-reset valid", 64'(out_valid), 64'd1);
    check("pre-reset result", 64'(result), 64'd11);
    #2;
    reset = 1'b1;
    #1;
    check("mid reset valid", 64'(out_valid), 64'd0);
    check("mid reset result", 64'(result), 64'd0);
    check("mid reset nzcv", 64'({n, z, c, v}), 64'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    check("post-reset idle", 64'(out_valid), 64'd0);
    do_op("post-reset add", 2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 4'b0000);

`ifdef ADD_PIPE_SATURATE_EN
    do_op("sat add", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0001);
    do_op("sat sub", 2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 4'b1011);
    do_op("nosat add", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 4'b1001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
